// File: rtl/alu_cmd_seq_pkg.sv
// ============================================================================
//  alu_cmd_seq_pkg
//  Shared state encoding, default opcodes and ALU wait timeout.
//  Rev 1.0
// ============================================================================
`default_nettype none

package alu_cmd_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_GET_A    = 3'd1,
        S_GET_B    = 3'd2,
        S_GET_FUN  = 3'd3,
        S_ALU_RUN  = 3'd4,
        S_ALU_WAIT = 3'd5,
        S_SEND_LO  = 3'd6,
        S_SEND_HI  = 3'd7
    } seq_state_e;

    localparam logic [7:0] DEF_CMD_OPR  = 8'hCC;
    localparam logic [7:0] DEF_CMD_NOPR = 8'hDD;

    // Cycles spent in ALU_WAIT before giving up on the result
    localparam int WAIT_TIMEOUT = 4;
    localparam int TMO_W        = $clog2(WAIT_TIMEOUT);

endpackage

`default_nettype wire

// File: rtl/alu_cmd_seq.sv
// ============================================================================
//  alu_cmd_seq
//  Decodes RX command bytes, drives the ALU and returns the result over TX.
//  Rev 1.0
// ============================================================================
`default_nettype none

module alu_cmd_seq
    import alu_cmd_seq_pkg::*;
#(
    parameter int                 D_WIDTH   = 8,
    parameter int                 FUN_WIDTH = 4,
    parameter logic [D_WIDTH-1:0] CMD_OPR   = D_WIDTH'(DEF_CMD_OPR),
    parameter logic [D_WIDTH-1:0] CMD_NOPR  = D_WIDTH'(DEF_CMD_NOPR)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [D_WIDTH-1:0]     RX_P_DATA,
    input  logic                   RX_D_VLD,
    output logic [D_WIDTH-1:0]     ALU_A,
    output logic [D_WIDTH-1:0]     ALU_B,
    output logic [FUN_WIDTH-1:0]   ALU_FUN,
    output logic                   ALU_EN,
    output logic                   ALU_CLK_EN,
    input  logic [2*D_WIDTH-1:0]   ALU_OUT,
    input  logic                   ALU_OUT_VLD,
    output logic [D_WIDTH-1:0]     TX_P_DATA,
    output logic                   TX_D_VLD,
    input  logic                   TX_BUSY,
    output logic                   SEQ_BUSY
);

    seq_state_e           state;
    seq_state_e           next_state;
    logic [D_WIDTH-1:0]   op_a;
    logic [D_WIDTH-1:0]   op_b;
    logic [FUN_WIDTH-1:0] fun;
    logic [2*D_WIDTH-1:0] result;
    logic [D_WIDTH-1:0]   tx_data;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 alu_en_q;
    logic                 tx_vld_q;
    logic                 tx_fire;
    logic                 tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_W'(WAIT_TIMEOUT - 1));

    // A byte may only go out once the transmitter has had a cycle to raise busy
    always_comb begin
        tx_fire = 1'b0;
        if ((state == S_SEND_LO) || (state == S_SEND_HI)) begin
            tx_fire = !TX_BUSY && !tx_vld_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_OPR) begin
                        next_state = S_GET_A;
                    end else if (RX_P_DATA == CMD_NOPR) begin
                        next_state = S_GET_FUN;
                    end
                end
            end
            S_GET_A:    if (RX_D_VLD) next_state = S_GET_B;
            S_GET_B:    if (RX_D_VLD) next_state = S_GET_FUN;
            S_GET_FUN:  if (RX_D_VLD) next_state = S_ALU_RUN;
            S_ALU_RUN:  next_state = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    next_state = S_SEND_LO;
                end else if (tmo_hit) begin
                    next_state = S_IDLE;
                end
            end
            S_SEND_LO:  if (tx_fire) next_state = S_SEND_HI;
            S_SEND_HI:  if (tx_fire) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        SEQ_BUSY   = (state != S_IDLE);
        ALU_CLK_EN = (state == S_GET_FUN) || (state == S_ALU_RUN) ||
                     (state == S_ALU_WAIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_a     <= '0;
            op_b     <= '0;
            fun      <= '0;
            result   <= '0;
            tx_data  <= '0;
            tmo_cnt  <= '0;
            alu_en_q <= 1'b0;
            tx_vld_q <= 1'b0;
        end else begin
            if ((state == S_GET_A) && RX_D_VLD) begin
                op_a <= RX_P_DATA;
            end
            if ((state == S_GET_B) && RX_D_VLD) begin
                op_b <= RX_P_DATA;
            end
            if ((state == S_GET_FUN) && RX_D_VLD) begin
                fun <= RX_P_DATA[FUN_WIDTH-1:0];
            end
            if ((state == S_ALU_WAIT) && ALU_OUT_VLD) begin
                result <= ALU_OUT;
            end
            if ((state == S_ALU_WAIT) && (next_state == S_ALU_WAIT)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            // Registered so the pulse coincides exactly with the ALU_RUN cycle
            alu_en_q <= (next_state == S_ALU_RUN);
            tx_vld_q <= tx_fire;
            if (tx_fire) begin
                tx_data <= (state == S_SEND_LO) ? result[D_WIDTH-1:0]
                                                : result[2*D_WIDTH-1:D_WIDTH];
            end
        end
    end

    assign ALU_A     = op_a;
    assign ALU_B     = op_b;
    assign ALU_FUN   = fun;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data;
    assign TX_D_VLD  = tx_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
// ============================================================================
//  tb_alu_cmd_seq
//  Randomized command stream with a fake ALU, fake transmitter and scoreboard.
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_cmd_seq;

    localparam logic [7:0] CC = 8'hCC;
    localparam logic [7:0] DD = 8'hDD;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, ALU_CLK_EN, TX_D_VLD, SEQ_BUSY;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_BUSY = 1'b0;

    alu_cmd_seq dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .ALU_CLK_EN(ALU_CLK_EN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .SEQ_BUSY(SEQ_BUSY)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  fun;
        logic [15:0] res;
        logic [1:0]  dly;
        logic        hold;
    } alu_exp_t;

    alu_exp_t   alu_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    bit         hold_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    // Stand-in ALU behaviour; the sequencer only forwards the 16-bit result
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {b, a};
        endcase
    endfunction

    // ---------------- fake ALU + ALU-side monitor ----------------
    int         wait_cnt = 0;
    int         to_cnt = 0;
    bit         tracking = 1'b0;
    bit         chk_clk_drop = 1'b0;
    bit         prev_en = 1'b0;
    logic [15:0] pend_res = '0;

    always @(negedge CLK) begin
        alu_exp_t e;
        if (!RST) begin
            wait_cnt = 0; tracking = 0; chk_clk_drop = 0; prev_en = 0;
            ALU_OUT_VLD = 1'b0;
        end else begin
            ALU_OUT_VLD = 1'b0;
            if (chk_clk_drop) begin
                check("clk_en_after_result", ALU_CLK_EN, 0);
                chk_clk_drop = 0;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    check("clk_en_in_wait", ALU_CLK_EN, 1);
                    ALU_OUT     = pend_res;
                    ALU_OUT_VLD = 1'b1;
                    chk_clk_drop = 1;
                end
            end
            if (tracking) begin
                to_cnt++;
                if (!SEQ_BUSY) begin
                    check("timeout_cycles", to_cnt, 5);
                    check("clk_en_after_timeout", ALU_CLK_EN, 0);
                    tracking = 0;
                end else if (to_cnt > 20) begin
                    flag("timeout_never_idle");
                    tracking = 0;
                end
            end
            if (ALU_EN) begin
                check("alu_en_single_cycle", prev_en, 0);
                check("alu_en_clk_en", ALU_CLK_EN, 1);
                if (alu_q.size() == 0) begin
                    flag("alu_en_unexpected");
                end else begin
                    e = alu_q.pop_front();
                    check("alu_a", ALU_A, e.a);
                    check("alu_b", ALU_B, e.b);
                    check("alu_fun", ALU_FUN, e.fun);
                    if (e.hold) begin
                        tracking = 1; to_cnt = 0;
                    end else begin
                        wait_cnt = int'(e.dly) + 1;
                        pend_res = e.res;
                    end
                end
            end
            prev_en = ALU_EN;
        end
    end

    // ---------------- fake transmitter + TX monitor ----------------
    int         busy_cnt = 0;
    logic [7:0] last_tx = '0;
    bit         prev_vld = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            busy_cnt = 0; last_tx = '0; prev_vld = 0;
            TX_BUSY = hold_busy;
        end else begin
            if (TX_D_VLD) begin
                check("tx_busy_respected", TX_BUSY, 0);
                check("tx_no_back_to_back", prev_vld, 0);
                if (tx_q.size() == 0) flag("tx_unexpected");
                else check("tx_byte", TX_P_DATA, tx_q.pop_front());
                last_tx  = TX_P_DATA;
                busy_cnt = $urandom_range(0, 4);
            end else begin
                check("tx_data_hold", TX_P_DATA, last_tx);
                if (busy_cnt > 0) busy_cnt--;
            end
            prev_vld = TX_D_VLD;
            TX_BUSY  = hold_busy || (busy_cnt > 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    // Operand/function bytes after the opcode; pushes expectations first
    task automatic cmd_body(input bit opr, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] f, input logic [1:0] dly, input bit hold);
        alu_exp_t   e;
        logic [3:0] junk;
        if (opr) begin
            m_a = a;
            m_b = b;
        end
        e.a = m_a; e.b = m_b; e.fun = f; e.res = alu_ref(m_a, m_b, f);
        e.dly = dly; e.hold = hold;
        alu_q.push_back(e);
        if (!hold) begin
            tx_q.push_back(e.res[7:0]);
            tx_q.push_back(e.res[15:8]);
        end
        if (opr) begin
            gap(); send_byte(a);
            gap(); send_byte(b);
        end
        gap();
        junk = 4'($urandom);
        send_byte({junk, f});
    endtask

    task automatic issue_cmd(input bit opr, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] f, input logic [1:0] dly, input bit hold);
        send_byte(opr ? CC : DD);
        check("opcode_accepted", SEQ_BUSY, 1);
        check("clk_en_after_opcode", ALU_CLK_EN, opr ? 0 : 1);
        cmd_body(opr, a, b, f, dly, hold);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((SEQ_BUSY || alu_q.size() != 0 || tx_q.size() != 0) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("return_to_idle", n < 200, 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {ALU_A, ALU_B, ALU_FUN, ALU_EN, ALU_CLK_EN, TX_P_DATA, TX_D_VLD, SEQ_BUSY}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, junk;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset_outputs");
        #2 RST = 1'b1;

        // add 05+03 -> 0008
        issue_cmd(1, 8'h05, 8'h03, 4'd0, 2'd1, 0);
        wait_idle();
        // mul reusing stored operands -> 000F
        issue_cmd(0, 8'h00, 8'h00, 4'd2, 2'd0, 0);
        wait_idle();

        // stray byte in IDLE is dropped
        send_byte(8'h7A);
        check("stray_byte_dropped", SEQ_BUSY, 0);
        repeat (3) @(negedge CLK);
        check("stray_byte_still_idle", SEQ_BUSY, 0);

        // transmitter busy across the result phase
        @(posedge CLK); #1 hold_busy = 1'b1;
        issue_cmd(1, 8'($urandom), 8'($urandom), 4'($urandom), 2'd0, 0);
        repeat (12) @(negedge CLK);
        check("stalled_in_send", SEQ_BUSY, 1);
        check("no_tx_while_busy", tx_q.size(), 2);
        @(posedge CLK); #1 hold_busy = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        check("tx_first_free_cycle", TX_D_VLD, 1);
        wait_idle();

        // result withheld -> timeout; a byte during ALU_WAIT is dropped
        issue_cmd(1, 8'($urandom), 8'($urandom), 4'($urandom), 2'd0, 1);
        repeat (1) @(negedge CLK);
        send_byte(CC);
        wait_idle();
        repeat (3) @(negedge CLK);
        check("byte_in_wait_dropped", SEQ_BUSY, 0);

        // reset in GET_B aborts; first byte afterwards decoded as opcode
        send_byte(CC);
        send_byte(8'h5A);
        #2 RST = 1'b0;
        #1 check_reset_outputs("reset_mid_command");
        m_a = '0;
        m_b = '0;
        @(negedge CLK);
        #2 RST = 1'b1;
        send_byte(8'h05);
        check("post_reset_05_dropped", SEQ_BUSY, 0);
        send_byte(CC);
        check("post_reset_cc_get_a", SEQ_BUSY, 1);
        cmd_body(1, 8'($urandom), 8'($urandom), 4'($urandom), 2'($urandom), 0);
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) begin
                do junk = 8'($urandom); while (junk == CC || junk == DD);
                send_byte(junk);
                check("random_junk_dropped", SEQ_BUSY, 0);
            end else begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                issue_cmd(r < 6, ra, rb, 4'($urandom), 2'($urandom),
                          $urandom_range(0, 7) == 0);
                wait_idle();
            end
        end

        check("alu_queue_drained", alu_q.size(), 0);
        check("tx_queue_drained", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
